// File: rtl/i2c_codec_target_if.sv
// I2C codec target bus bundle: SCL/SDA pins in, ACK drive and
// register-write results out.
interface i2c_codec_target_if;
   logic       i_sclk;
   logic       i_sdat;
   logic       o_sda_oe;
   logic       o_reg_wr;
   logic [6:0] o_reg_addr;
   logic [8:0] o_reg_data;
   logic       o_busy;
   logic       o_frame_err;

   // master: the I2C bus / host side that drives the pins
   modport master (
      output i_sclk, i_sdat,
      input  o_sda_oe, o_reg_wr, o_reg_addr, o_reg_data, o_busy, o_frame_err
   );

   // slave: the codec target block
   modport slave (
      input  i_sclk, i_sdat,
      output o_sda_oe, o_reg_wr, o_reg_addr, o_reg_data, o_busy, o_frame_err
   );
endinterface

// File: rtl/i2c_codec_target.sv
// I2C write-only codec control target. It accepts the frame
// START, {DEV_ADDR,W}, {reg[6:0],d[8]}, d[7:0], and then issues one
// register-write strobe.
module i2c_codec_target #(
   parameter logic [6:0] DEV_ADDR  = 7'h1A,
   parameter int         MIN_PHASE = 4
) (
   input logic           i_clk,
   input logic           i_rst,
   i2c_codec_target_if.slave bus
);

   // Edge detection lags the pins by three cycles, so very short SCL phases would smear.
   if (MIN_PHASE < 3) begin : g_phase_chk
      $error("MIN_PHASE must be at least 3");
   end

   typedef enum logic [2:0] {IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, IGNORE} state_t;

   state_t     state, state_nx;
   logic       scl_s1, scl_s2, scl_d, sda_s1, sda_s2, sda_d;
   logic [1:0] settle;
   logic       armed, scl_rise, scl_fall, start_c, stop_c;
   logic [2:0] cnt;
   logic [7:0] sh, byte_nx;
   logic [6:0] cap_addr;
   logic       cap_d8;
   logic       sda_oe, sda_oe_nx, wr_nx, err_nx, cnt_clr, shift_en, cap_en;

   // Two-flop synchronizers plus an edge-detect stage. The settle count masks
   // the false edges that appear while the synchronizers refill after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         {scl_s1, scl_s2, scl_d} <= 3'b111;
         {sda_s1, sda_s2, sda_d} <= 3'b111;
         settle                  <= 2'd0;
      end else begin
         {scl_s1, scl_s2, scl_d} <= {bus.i_sclk, scl_s1, scl_s2};
         {sda_s1, sda_s2, sda_d} <= {bus.i_sdat, sda_s1, sda_s2};
         if (!armed) settle <= settle + 2'd1;
      end
   end

   assign armed    = (settle == 2'd3);
   assign scl_rise = armed &  scl_s2 & ~scl_d;
   assign scl_fall = armed & ~scl_s2 &  scl_d;
   assign start_c  = armed & scl_s2 & scl_d &  sda_d & ~sda_s2;
   assign stop_c   = armed & scl_s2 & scl_d & ~sda_d &  sda_s2;
   assign byte_nx  = {sh[6:0], sda_s2};

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nx;
   end

   // Next state and strobes. The ACK states drive SDA from the first SCL fall to the second.
   always_comb begin
      state_nx  = state;
      sda_oe_nx = 1'b0;
      wr_nx     = 1'b0;
      err_nx    = 1'b0;
      cnt_clr   = 1'b0;
      shift_en  = 1'b0;
      cap_en    = 1'b0;
      case (state)
         IDLE: if (start_c) begin
            state_nx = ADDR;
            cnt_clr  = 1'b1;
         end
         ADDR, REG, DATA: if (scl_rise) begin
            shift_en = 1'b1;
            if (cnt == 3'd7) begin
               if (state == REG)       state_nx = ACK_R;
               else if (state == DATA) state_nx = ACK_D;
               else if (byte_nx[7:1] == DEV_ADDR && !byte_nx[0]) state_nx = ACK_A;
               else                    state_nx = IGNORE;
            end
         end
         ACK_A, ACK_R, ACK_D: begin
            sda_oe_nx = sda_oe;
            if (scl_fall) begin
               if (!sda_oe) begin
                  sda_oe_nx = 1'b1;
               end else begin
                  sda_oe_nx = 1'b0;
                  cnt_clr   = 1'b1;
                  case (state)
                     ACK_A:   state_nx = REG;
                     ACK_R:   begin state_nx = DATA; cap_en = 1'b1; end
                     default: begin state_nx = IGNORE; wr_nx = 1'b1; end
                  endcase
               end
            end
         end
         default: ;
      endcase
      // Bus conditions override the byte engine and any ACK in progress.
      if (stop_c) begin
         state_nx  = IDLE;
         sda_oe_nx = 1'b0;
         wr_nx     = 1'b0;
         cap_en    = 1'b0;
         shift_en  = 1'b0;
         err_nx    = (state != IDLE) && (state != IGNORE);
      end else if (start_c && state != IDLE) begin
         state_nx  = ADDR;
         cnt_clr   = 1'b1;
         sda_oe_nx = 1'b0;
         wr_nx     = 1'b0;
         cap_en    = 1'b0;
         shift_en  = 1'b0;
         err_nx    = (state == REG) || (state == ACK_R) || (state == DATA) || (state == ACK_D);
      end
   end

   // Datapath: bit shifter, byte-2 capture, registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt             <= 3'd0;
         sh              <= 8'd0;
         cap_addr        <= 7'd0;
         cap_d8          <= 1'b0;
         sda_oe          <= 1'b0;
         bus.o_reg_wr    <= 1'b0;
         bus.o_frame_err <= 1'b0;
         bus.o_busy      <= 1'b0;
         bus.o_reg_addr  <= 7'd0;
         bus.o_reg_data  <= 9'd0;
      end else begin
         if (cnt_clr)       cnt <= 3'd0;
         else if (shift_en) cnt <= cnt + 3'd1;
         if (shift_en) sh <= byte_nx;
         if (cap_en) begin
            cap_addr <= sh[7:1];
            cap_d8   <= sh[0];
         end
         sda_oe          <= sda_oe_nx;
         bus.o_reg_wr    <= wr_nx;
         bus.o_frame_err <= err_nx;
         bus.o_busy      <= (state_nx != IDLE);
         if (wr_nx) begin
            bus.o_reg_addr <= cap_addr;
            bus.o_reg_data <= {cap_d8, sh};
         end
      end
   end

   assign bus.o_sda_oe = sda_oe;

endmodule

// File: tb/tb_i2c_codec_target.sv
// Directed bench for i2c_codec_target: a bit-level I2C master with a
// scoreboard of expected register writes.
module tb_i2c_codec_target;
   localparam int P = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sclk = 1'b1;
   logic sda_m = 1'b1;
   int   n_chk = 0, n_pass = 0;
   int   wr_cnt = 0, err_cnt = 0;
   logic oe_seen = 1'b0;
   logic [15:0] sb[$];

   i2c_codec_target_if ifc ();
   assign ifc.i_sclk = sclk;
   assign ifc.i_sdat = sda_m & ~ifc.o_sda_oe;

   i2c_codec_target #(.DEV_ADDR(7'h1A), .MIN_PHASE(P)) dut (
      .i_clk(clk), .i_rst(rst), .bus(ifc.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      cyc(P); sda_m = b;
      cyc(P); sclk = 1'b1;
      cyc(P); sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i]);
      cyc(P); sda_m = 1'b1;
      cyc(P); sclk = 1'b1;
      cyc(P / 2); ack = ifc.o_sda_oe;
      cyc(P - P / 2); sclk = 1'b0;
   endtask

   task automatic do_start();
      cyc(2 * P); sda_m = 1'b1;
      cyc(P); sclk = 1'b1;
      cyc(P); sda_m = 1'b0;
      cyc(P); sclk = 1'b0;
   endtask

   task automatic do_stop();
      cyc(2 * P); sda_m = 1'b0;
      cyc(P); sclk = 1'b1;
      cyc(P); sda_m = 1'b1;
      cyc(2 * P);
   endtask

   // Write-strobe monitor: pops the scoreboard on each o_reg_wr.
   always @(negedge clk) begin
      logic [15:0] e;
      if (ifc.o_sda_oe) oe_seen = 1'b1;
      if (ifc.o_frame_err) err_cnt++;
      if (ifc.o_reg_wr) begin
         wr_cnt++;
         chk("wr_expected", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_addr", 32'(ifc.o_reg_addr), 32'(e[15:9]));
            chk("wr_data", 32'(ifc.o_reg_data), 32'(e[8:0]));
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a1, a2, a3, a4;
      int   w0, e0;
      logic [15:0] tbl [10];
      tbl = '{16'h1E00, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
              16'h0812, 16'h0A00, 16'h0C00, 16'h0E42, 16'h1201};

      // reset state
      cyc(3);
      chk("reset_outs", 32'({ifc.o_sda_oe, ifc.o_reg_wr, ifc.o_busy, ifc.o_frame_err,
                             ifc.o_reg_addr, ifc.o_reg_data}), 32'd0);
      rst = 1'b0;
      cyc(5);

      // basic write 0x34 0x12 0x01
      w0 = wr_cnt; e0 = err_cnt;
      sb.push_back({7'h09, 9'h001});
      do_start();
      cyc(2);
      chk("busy_after_start", 32'(ifc.o_busy), 32'd1);
      send_byte(8'h34, a1); send_byte(8'h12, a2); send_byte(8'h01, a3);
      do_stop();
      chk("t1_ack", 32'({a1, a2, a3}), 32'b111);
      chk("t1_wr_cnt", 32'(wr_cnt - w0), 32'd1);
      chk("t1_err", 32'(err_cnt - e0), 32'd0);
      chk("t1_addr", 32'(ifc.o_reg_addr), 32'h09);
      chk("t1_data", 32'(ifc.o_reg_data), 32'h001);
      chk("t1_busy", 32'(ifc.o_busy), 32'd0);

      // wrong device address
      w0 = wr_cnt; e0 = err_cnt; oe_seen = 1'b0;
      do_start();
      send_byte(8'h36, a1); send_byte(8'h00, a2); send_byte(8'h00, a3);
      do_stop();
      chk("t2_ack", 32'({a1, a2, a3}), 32'b000);
      chk("t2_oe_seen", 32'(oe_seen), 32'd0);
      chk("t2_wr_cnt", 32'(wr_cnt - w0), 32'd0);
      chk("t2_err", 32'(err_cnt - e0), 32'd0);
      chk("t2_busy", 32'(ifc.o_busy), 32'd0);

      // data bit 8 and an ignored fourth byte
      w0 = wr_cnt; e0 = err_cnt;
      sb.push_back({7'h07, 9'h179});
      do_start();
      send_byte(8'h34, a1); send_byte(8'h0F, a2); send_byte(8'h79, a3); send_byte(8'hFF, a4);
      do_stop();
      chk("t3_ack", 32'({a1, a2, a3, a4}), 32'b1110);
      chk("t3_wr_cnt", 32'(wr_cnt - w0), 32'd1);
      chk("t3_err", 32'(err_cnt - e0), 32'd0);
      chk("t3_addr", 32'(ifc.o_reg_addr), 32'h07);
      chk("t3_data", 32'(ifc.o_reg_data), 32'h179);

      // STOP after two bytes aborts
      w0 = wr_cnt; e0 = err_cnt;
      do_start();
      send_byte(8'h34, a1); send_byte(8'h12, a2);
      do_stop();
      chk("t4a_err", 32'(err_cnt - e0), 32'd1);
      chk("t4a_wr_cnt", 32'(wr_cnt - w0), 32'd0);
      chk("t4a_hold", 32'({ifc.o_reg_addr, ifc.o_reg_data}), 32'({7'h07, 9'h179}));

      // repeated START mid-frame aborts, then a complete frame follows
      w0 = wr_cnt; e0 = err_cnt;
      sb.push_back({7'h00, 9'h097});
      do_start();
      send_byte(8'h34, a1);
      do_start();
      send_byte(8'h34, a1); send_byte(8'h00, a2); send_byte(8'h97, a3);
      do_stop();
      chk("t4b_err", 32'(err_cnt - e0), 32'd1);
      chk("t4b_wr_cnt", 32'(wr_cnt - w0), 32'd1);
      chk("t4b_ack", 32'({a1, a2, a3}), 32'b111);

      // reset during bit 5 of byte 3
      w0 = wr_cnt; e0 = err_cnt;
      do_start();
      send_byte(8'h34, a1); send_byte(8'h12, a2);
      for (int i = 7; i >= 4; i--) send_bit(1'b1);
      cyc(P); sda_m = 1'b0;
      cyc(P); sclk = 1'b1;
      cyc(1); rst = 1'b1;
      cyc(1);
      chk("t5_reset_outs", 32'({ifc.o_sda_oe, ifc.o_reg_wr, ifc.o_busy, ifc.o_frame_err,
                                ifc.o_reg_addr, ifc.o_reg_data}), 32'd0);
      sclk = 1'b1; sda_m = 1'b1;
      cyc(3); rst = 1'b0;
      cyc(8);
      chk("t5_no_strobes", 32'({wr_cnt - w0, err_cnt - e0}), 32'd0);
      sb.push_back({7'h15, 9'h055});
      do_start();
      send_byte(8'h34, a1); send_byte(8'h2A, a2); send_byte(8'h55, a3);
      do_stop();
      chk("t5_ack", 32'({a1, a2, a3}), 32'b111);
      chk("t5_wr_cnt", 32'(wr_cnt - w0), 32'd1);

      // back-to-back setup table
      w0 = wr_cnt; e0 = err_cnt;
      for (int k = 0; k < 10; k++) begin
         sb.push_back(tbl[k]);
         do_start();
         send_byte(8'h34, a1); send_byte(tbl[k][15:8], a2); send_byte(tbl[k][7:0], a3);
         do_stop();
      end
      chk("t6_wr_cnt", 32'(wr_cnt - w0), 32'd10);
      chk("t6_err", 32'(err_cnt - e0), 32'd0);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_codec_target.md
I2C_CODEC_TARGET -- requirements
Module: i2c_codec_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'h1A, 7-bit I2C device address the block answers to.
REQ-002 Parameter MIN_PHASE, default 4, minimum i_clk cycles that i_sclk is guaranteed high or low; used only by the bench.
REQ-003 i_clk  input  1  system clock. One clock; all state is on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_sclk  input  1  I2C SCL from the bus (asynchronous).
REQ-006 i_sdat  input  1  I2C SDA as seen on the bus (asynchronous).
REQ-007 o_sda_oe  output  1  1 = pull SDA low (ACK); 0 = release.
REQ-008 o_reg_wr  output  1  one-cycle strobe when a complete register write is accepted.
REQ-009 o_reg_addr  output  7  codec register address of the last accepted write.
REQ-010 o_reg_data  output  9  codec register data of the last accepted write.
REQ-011 o_busy  output  1  high from a detected START until a STOP or the return to IDLE.
REQ-012 o_frame_err  output  1  one-cycle strobe when a frame is aborted.

Function
REQ-013 Synchronize i_sclk and i_sdat through two flops each, then register once more for edge detection. A pin change is visible as an edge 3 cycles later.
REQ-014 Conditions, evaluated on the synchronized signals:
- START = SDA falling while SCL high.
- STOP = SDA rising while SCL high.
- Data bits are sampled on SCL rising edges, MSB first.
REQ-015 States: IDLE, ADDR, ACK_A, REG, ACK_R, DATA, ACK_D, IGNORE.
REQ-016 State transitions:
- IDLE -> ADDR on START. Clear the bit counter to 0 and set o_busy.
- ADDR/REG/DATA -> matching ACK_x after the 8th sampled bit.
REQ-017 Address byte handling:
- If byte[7:1]==DEV_ADDR and byte[0]==0: ACK it.
- Otherwise: no ACK; go to IGNORE and raise no error.
REQ-018 ACK timing: o_sda_oe rises in the cycle after the first detected SCL falling edge following the 8th bit. It falls in the cycle after the next detected SCL falling edge.
REQ-019 ACK state exits:
- ACK_A -> REG.
- ACK_R -> DATA. Byte 2 is captured as reg_addr = byte[7:1] and data[8] = byte[0].
- ACK_D -> IGNORE.
REQ-020 On leaving ACK_D:
- o_reg_addr and o_reg_data take {captured address, captured data[8], byte 3}.
- o_reg_wr pulses for exactly one cycle, in the same cycle o_sda_oe falls.
REQ-021 Bytes after the third are not ACKed and produce no write. The block stays in IGNORE until STOP or START.
REQ-022 STOP in any state returns to IDLE and clears o_busy. If the STOP arrives in ADDR through ACK_D before REQ-020 fires, pulse o_frame_err for one cycle and discard partial data.
REQ-023 Repeated START in any non-IDLE state goes to ADDR with the bit counter cleared.
- It pulses o_frame_err only if a frame was mid-way (REG through ACK_D before the write).
- It releases o_sda_oe the next cycle.
REQ-024 START or STOP detected while o_sda_oe=1 overrides the ACK; o_sda_oe drops the next cycle.
REQ-025 o_sda_oe is never asserted outside ACK_A, ACK_R and ACK_D.
REQ-026 o_reg_addr and o_reg_data hold their values between writes.

Reset
REQ-027 While i_rst=1:
- State is IDLE.
- Synchronizers are 1.
- o_sda_oe, o_reg_wr, o_busy and o_frame_err are 0.
- o_reg_addr and o_reg_data are 0.
REQ-028 Reset asserted mid-frame aborts immediately with no o_reg_wr and no o_frame_err. After release, the block waits for a fresh START; a frame already in progress is ignored.

Verification
REQ-029 START, then 0x34, 0x12, 0x01, then STOP, with 4-cycle SCL phases:
- ACK is asserted on all three bytes.
- o_reg_wr pulses once.
- o_reg_addr=7'h09 and o_reg_data=9'h001.
REQ-030 Wrong address: START, 0x36, 0x00, 0x00, STOP:
- o_sda_oe stays 0 throughout.
- No o_reg_wr and no o_frame_err.
- o_busy falls after the STOP.
REQ-031 Data bit 8: START, 0x34, 0x0F, 0x79, STOP gives o_reg_addr=7'h07 and o_reg_data=9'h179. A following 4th byte 0xFF before the STOP gets no ACK and no second strobe.
REQ-032 Abort cases:
- START, 0x34, 0x12, then STOP gives one o_frame_err and no write; outputs keep their previous values.
- START, 0x34, then repeated START, 0x34, 0x00, 0x97 gives one o_frame_err, then a write of addr 7'h00, data 9'h097.
REQ-033 Reset during the 5th bit of byte 3 of a valid frame:
- All outputs are 0 within 1 cycle of i_rst rising.
- A full frame after release is accepted normally.
REQ-034 Back-to-back frames: ten frames taken from the codec setup table, separated by STOP/START. This gives exactly ten o_reg_wr pulses with matching address/data in order, and never o_frame_err.
